// File: rtl/seq_game_uc_param_if.sv
// Handshake bundle between the sequence-game control unit and its datapath / player I/O.
interface seq_game_uc_param_if #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned LIVES_W = 2
);
  // Player and datapath inputs to the control unit
  logic              jogar;
  logic              jogada;
  logic              jogada_correta;
  logic              modo;
  logic              timeout_en;

  // Control unit outputs
  logic [ADDR_W-1:0]  endereco;
  logic [ADDR_W-1:0]  rodada;
  logic [LIVES_W-1:0] vidas;
  logic               limpaRC;
  logic               registraRC;
  logic               zeraLeds;
  logic               registraLeds;
  logic               ram_we;
  logic               led_selector;
  logic               led_off;
  logic               ganhou;
  logic               perdeu;
  logic               pronto;
  logic               db_timeout;
  logic [4:0]         db_estado;

  modport master (
    output jogar, jogada, jogada_correta, modo, timeout_en,
    input  endereco, rodada, vidas, limpaRC, registraRC, zeraLeds, registraLeds, ram_we,
           led_selector, led_off, ganhou, perdeu, pronto, db_timeout, db_estado
  );

  modport slave (
    input  jogar, jogada, jogada_correta, modo, timeout_en,
    output endereco, rodada, vidas, limpaRC, registraRC, zeraLeds, registraLeds, ram_we,
           led_selector, led_off, ganhou, perdeu, pronto, db_timeout, db_estado
  );
endinterface

// File: rtl/seq_game_uc_param.sv
// Control unit for the sequence-memory game: FSM plus round, address, timer and lives counters.
module seq_game_uc_param #(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned NUM_ROUNDS     = 16,
  parameter int unsigned FIRST_SHOW_CYC = 2000,
  parameter int unsigned SHOW_CYC       = 500,
  parameter int unsigned GAP_CYC        = 100,
  parameter int unsigned TIMEOUT_CYC    = 5000,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned LIVES_W        = 2
) (
  input  logic                clock,
  input  logic                reset,
  seq_game_uc_param_if.slave  uc
);

  // One shared timer covers every timed state, so size it for the longest one
  localparam int unsigned MaxAB  = (FIRST_SHOW_CYC > SHOW_CYC) ? FIRST_SHOW_CYC : SHOW_CYC;
  localparam int unsigned MaxCD  = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int unsigned MaxCyc = (MaxAB > MaxCD) ? MaxAB : MaxCD;
  localparam int unsigned TimerW = (MaxCyc < 2) ? 1 : $clog2(MaxCyc);

  localparam logic [TimerW-1:0]  FirstLast   = TimerW'(FIRST_SHOW_CYC - 1);
  localparam logic [TimerW-1:0]  ShowLast    = TimerW'(SHOW_CYC - 1);
  localparam logic [TimerW-1:0]  GapLast     = TimerW'(GAP_CYC - 1);
  localparam logic [TimerW-1:0]  TimeoutLast = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0]  RoundLast   = ADDR_W'(NUM_ROUNDS - 1);
  localparam logic [LIVES_W-1:0] LivesInit   = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LivesOne    = LIVES_W'(1);

  typedef enum logic [4:0] {
    StIdle       = 5'h00,
    StPrep       = 5'h01,
    StInicia     = 5'h02,
    StEspera     = 5'h03,
    StRegistra   = 5'h04,
    StCompara    = 5'h05,
    StProxJogada = 5'h06,
    StUltima     = 5'h07,
    StProxRodada = 5'h08,
    StWrite      = 5'h09,
    StFimA       = 5'h0A,
    StAtualiza   = 5'h0B,
    StShowFirst  = 5'h0C,
    StFimT       = 5'h0D,
    StFimE       = 5'h0E,
    StShowSeq    = 5'h0F,
    StShowErr    = 5'h10,
    StShowOk     = 5'h11,
    StShowGap    = 5'h12,
    StPerdeVida  = 5'h13
  } state_e;

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [ADDR_W-1:0]  endereco_q, endereco_d;
  logic [ADDR_W-1:0]  rodada_q, rodada_d;
  logic [LIVES_W-1:0] vidas_q, vidas_d;
  logic               cause_q, cause_d;  // 1 = life lost by timeout, 0 = by wrong play
  logic               modo_q, modo_d;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:       if (uc.jogar) state_d = StPrep;
      StPrep:       state_d = StShowFirst;
      StShowFirst:  if (timer_q == FirstLast) state_d = StEspera;
      StInicia:     state_d = StShowSeq;
      StShowSeq: begin
        if (timer_q == ShowLast) begin
          state_d = (endereco_q == rodada_q) ? StEspera : StShowGap;
        end
      end
      StShowGap:    if (timer_q == GapLast) state_d = StShowSeq;
      StEspera: begin
        // A press landing in the expiry cycle still counts as a play
        if (uc.jogada) begin
          state_d = StRegistra;
        end else if (uc.timeout_en && (timer_q == TimeoutLast)) begin
          state_d = StPerdeVida;
        end
      end
      StRegistra:   state_d = StAtualiza;
      StAtualiza:   state_d = StCompara;
      StCompara: begin
        if (!uc.jogada_correta) begin
          state_d = StShowErr;
        end else if (endereco_q != rodada_q) begin
          state_d = StProxJogada;
        end else begin
          state_d = StShowOk;
        end
      end
      StProxJogada: state_d = StEspera;
      StShowErr:    if (timer_q == ShowLast) state_d = StPerdeVida;
      StPerdeVida: begin
        if (vidas_q == LivesOne) begin
          state_d = cause_q ? StFimT : StFimE;
        end else begin
          state_d = StInicia;
        end
      end
      StShowOk: begin
        if (timer_q == ShowLast) begin
          if (rodada_q == RoundLast) begin
            state_d = StFimA;
          end else if (modo_q) begin
            state_d = StUltima;
          end else begin
            state_d = StProxRodada;
          end
        end
      end
      StUltima:     if (uc.jogada) state_d = StProxRodada;
      StProxRodada: state_d = modo_q ? StWrite : StInicia;
      StWrite:      state_d = StInicia;
      StFimA, StFimE, StFimT: if (uc.jogar) state_d = StPrep;
      default:      state_d = StIdle;
    endcase
  end

  // Counter and flag next-state, keyed on the current state and the transition taken
  always_comb begin
    timer_d    = (state_d != state_q) ? '0 : timer_q + TimerW'(1);
    endereco_d = endereco_q;
    rodada_d   = rodada_q;
    vidas_d    = vidas_q;
    cause_d    = cause_q;
    modo_d     = modo_q;
    case (state_q)
      StPrep: begin
        modo_d     = uc.modo;
        vidas_d    = LivesInit;
        endereco_d = '0;
        rodada_d   = '0;
      end
      StInicia:     endereco_d = '0;
      StShowSeq:    if (state_d == StEspera) endereco_d = '0;
      StShowGap:    if (state_d != StShowGap) endereco_d = endereco_q + ADDR_W'(1);
      StEspera:     if (state_d == StPerdeVida) cause_d = 1'b1;
      StCompara:    if (state_d == StShowErr) cause_d = 1'b0;
      StProxJogada: endereco_d = endereco_q + ADDR_W'(1);
      StPerdeVida:  vidas_d = vidas_q - LivesOne;
      StProxRodada: begin
        rodada_d   = rodada_q + ADDR_W'(1);
        endereco_d = endereco_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  // Counter and flag registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q    <= '0;
      endereco_q <= '0;
      rodada_q   <= '0;
      vidas_q    <= LivesInit;
      cause_q    <= 1'b0;
      modo_q     <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      endereco_q <= endereco_d;
      rodada_q   <= rodada_d;
      vidas_q    <= vidas_d;
      cause_q    <= cause_d;
      modo_q     <= modo_d;
    end
  end

  assign uc.endereco  = endereco_q;
  assign uc.rodada    = rodada_q;
  assign uc.vidas     = vidas_q;
  assign uc.db_estado = state_q;

  // Moore output decode
  always_comb begin
    uc.limpaRC      = 1'b0;
    uc.registraRC   = 1'b0;
    uc.zeraLeds     = 1'b0;
    uc.registraLeds = 1'b0;
    uc.ram_we       = 1'b0;
    uc.led_selector = 1'b0;
    uc.led_off      = 1'b0;
    uc.ganhou       = 1'b0;
    uc.perdeu       = 1'b0;
    uc.pronto       = 1'b0;
    uc.db_timeout   = 1'b0;
    case (state_q)
      StPrep: begin
        uc.limpaRC      = 1'b1;
        uc.registraLeds = 1'b1;
        uc.led_selector = 1'b1;
      end
      StShowFirst, StInicia, StShowSeq: uc.led_selector = 1'b1;
      StShowGap, StUltima:              uc.led_off      = 1'b1;
      StEspera: begin
        uc.led_off      = 1'b1;
        uc.registraLeds = 1'b1;
      end
      StRegistra: begin
        uc.registraRC   = 1'b1;
        uc.registraLeds = 1'b1;
      end
      StProxRodada: uc.registraRC = 1'b1;
      StWrite:      uc.ram_we     = 1'b1;
      StFimA: begin
        uc.pronto  = 1'b1;
        uc.ganhou  = 1'b1;
        uc.led_off = 1'b1;
      end
      StFimE: begin
        uc.pronto  = 1'b1;
        uc.perdeu  = 1'b1;
        uc.led_off = 1'b1;
      end
      StFimT: begin
        uc.pronto     = 1'b1;
        uc.perdeu     = 1'b1;
        uc.db_timeout = 1'b1;
      end
      StAtualiza, StCompara, StProxJogada, StShowErr, StShowOk, StPerdeVida: ;
      // IDLE and any unused code
      default: begin
        uc.zeraLeds     = 1'b1;
        uc.limpaRC      = 1'b1;
        uc.led_selector = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_game_uc_param.sv
// Directed bench for seq_game_uc_param with small game parameters.
module tb_seq_game_uc_param;

  localparam int unsigned AddrW  = 4;
  localparam int unsigned LivesW = 2;

  localparam logic [4:0] SIdle = 5'h00, SPrep = 5'h01, SInicia = 5'h02, SEspera = 5'h03;
  localparam logic [4:0] SRegistra = 5'h04, SCompara = 5'h05, SProxJog = 5'h06, SUltima = 5'h07;
  localparam logic [4:0] SProxRod = 5'h08, SWrite = 5'h09, SFimA = 5'h0A, SAtualiza = 5'h0B;
  localparam logic [4:0] SShowFirst = 5'h0C, SFimT = 5'h0D, SFimE = 5'h0E, SShowSeq = 5'h0F;
  localparam logic [4:0] SShowErr = 5'h10, SShowOk = 5'h11, SShowGap = 5'h12, SPerde = 5'h13;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  seq_game_uc_param_if #(.ADDR_W(AddrW), .LIVES_W(LivesW)) bus ();

  seq_game_uc_param #(
    .ADDR_W(AddrW), .NUM_ROUNDS(3), .FIRST_SHOW_CYC(8), .SHOW_CYC(4), .GAP_CYC(2),
    .TIMEOUT_CYC(10), .LIVES(2), .LIVES_W(LivesW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .uc(bus)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [4:0] st);
    check_eq(tag, bus.db_estado, st);
  endtask

  // Checks the current state and that it lasts exactly n cycles
  task automatic expect_span(input string tag, input logic [4:0] st, input int n);
    int cyc = 0;
    expect_state(tag, st);
    while (bus.db_estado == st && cyc < 200) begin
      cyc++;
      tick();
    end
    check_eq({tag, "_len"}, cyc, n);
  endtask

  // One player press from ESPERA through COMPARA; leaves the DUT in the state after COMPARA
  task automatic play(input logic ok);
    bus.jogada_correta = ok;
    bus.jogada = 1'b1;
    tick();
    expect_state("registra", SRegistra);
    bus.jogada = 1'b0;
    tick();
    expect_state("atualiza", SAtualiza);
    tick();
    expect_state("compara", SCompara);
    tick();
  endtask

  // Correct plays for addresses 0..r; ends in SHOW_OK
  task automatic round_ok(input int r);
    for (int i = 0; i <= r; i++) begin
      check_eq("play_addr", bus.endereco, i);
      play(1'b1);
      if (i < r) begin
        expect_state("prox_jogada", SProxJog);
        tick();
        expect_state("espera_next", SEspera);
      end
    end
  endtask

  // Replay of addresses 0..last starting in SHOW_SEQ; ends in ESPERA
  task automatic replay(input int last);
    for (int i = 0; i <= last; i++) begin
      check_eq("replay_addr", bus.endereco, i);
      expect_span("show_seq", SShowSeq, 4);
      if (i < last) expect_span("show_gap", SShowGap, 2);
    end
    expect_state("replay_end", SEspera);
    check_eq("replay_end_addr", bus.endereco, 0);
  endtask

  task automatic start_game(input logic m);
    bus.modo  = m;
    bus.jogar = 1'b1;
    tick();
    expect_state("prep", SPrep);
    bus.jogar = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    bus.jogar = 1'b0;
    bus.jogada = 1'b0;
    bus.jogada_correta = 1'b0;
    bus.modo = 1'b0;
    bus.timeout_en = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset / IDLE
    expect_state("idle", SIdle);
    check_eq("idle_end", bus.endereco, 0);
    check_eq("idle_rod", bus.rodada, 0);
    check_eq("idle_vidas", bus.vidas, 2);
    check_eq("idle_zera", bus.zeraLeds, 1);
    check_eq("idle_limpa", bus.limpaRC, 1);
    check_eq("idle_sel", bus.led_selector, 1);
    check_eq("idle_pronto", bus.pronto, 0);
    check_eq("idle_we", bus.ram_we, 0);

    // Win with modo=0
    bus.modo  = 1'b0;
    bus.jogar = 1'b1;
    tick();
    expect_state("prep", SPrep);
    check_eq("prep_regleds", bus.registraLeds, 1);
    bus.jogar = 1'b0;
    tick();
    expect_span("show_first", SShowFirst, 8);
    expect_state("espera0", SEspera);
    check_eq("espera_off", bus.led_off, 1);
    for (int r = 0; r < 2; r++) begin
      round_ok(r);
      expect_span("show_ok", SShowOk, 4);
      expect_state("prox_rodada", SProxRod);
      tick();
      expect_state("inicia", SInicia);
      check_eq("inicia_rod", bus.rodada, r + 1);
      tick();
      replay(r + 1);
    end
    round_ok(2);
    expect_span("show_ok_last", SShowOk, 4);
    expect_state("fim_a", SFimA);
    check_eq("win_ganhou", bus.ganhou, 1);
    check_eq("win_pronto", bus.pronto, 1);
    check_eq("win_perdeu", bus.perdeu, 0);
    check_eq("win_rod", bus.rodada, 2);

    // modo=1: player appends a play
    start_game(1'b1);
    expect_span("show_first_m1", SShowFirst, 8);
    round_ok(0);
    expect_span("show_ok_m1", SShowOk, 4);
    expect_state("ultima", SUltima);
    check_eq("ultima_off", bus.led_off, 1);
    bus.jogada = 1'b1;
    tick();
    bus.jogada = 1'b0;
    expect_state("prox_rod_m1", SProxRod);
    check_eq("prox_rod_rc", bus.registraRC, 1);
    check_eq("prox_rod_we", bus.ram_we, 0);
    tick();
    expect_state("write", SWrite);
    check_eq("write_we", bus.ram_we, 1);
    check_eq("write_end", bus.endereco, 1);
    check_eq("write_rod", bus.rodada, 1);
    tick();
    expect_state("inicia_m1", SInicia);
    check_eq("write_we_off", bus.ram_we, 0);
    tick();
    replay(1);

    // Wrong plays with lives
    round_ok(0);
    expect_state("prox_jog_err", SProxJog);
    tick();
    play(1'b0);
    expect_span("show_err", SShowErr, 4);
    expect_state("perde", SPerde);
    check_eq("perde_vidas_before", bus.vidas, 2);
    tick();
    expect_state("inicia_err", SInicia);
    check_eq("vidas_after", bus.vidas, 1);
    check_eq("rod_same", bus.rodada, 1);
    tick();
    replay(1);
    play(1'b0);
    expect_span("show_err2", SShowErr, 4);
    expect_state("perde2", SPerde);
    tick();
    expect_state("fim_e", SFimE);
    check_eq("fime_perdeu", bus.perdeu, 1);
    check_eq("fime_pronto", bus.pronto, 1);
    check_eq("fime_vidas", bus.vidas, 0);

    // Restart, timeout disabled, then timeouts
    start_game(1'b0);
    check_eq("restart_vidas", bus.vidas, 2);
    check_eq("restart_rod", bus.rodada, 0);
    expect_span("show_first_r", SShowFirst, 8);
    repeat (50) tick();
    expect_state("no_timeout", SEspera);
    round_ok(0);
    expect_span("show_ok_r", SShowOk, 4);
    tick();
    expect_state("inicia_r", SInicia);
    tick();
    replay(1);
    bus.timeout_en = 1'b1;
    expect_span("espera_to", SEspera, 10);
    expect_state("perde_to", SPerde);
    tick();
    expect_state("inicia_to", SInicia);
    check_eq("to_vidas", bus.vidas, 1);
    tick();
    replay(1);
    repeat (9) tick();
    expect_state("espera_last", SEspera);
    bus.jogada_correta = 1'b1;
    bus.jogada = 1'b1;
    tick();
    expect_state("jogada_wins", SRegistra);
    bus.jogada = 1'b0;
    tick();
    tick();
    tick();
    expect_state("prox_jog_to", SProxJog);
    tick();
    expect_span("espera_to2", SEspera, 10);
    expect_state("perde_to2", SPerde);
    tick();
    expect_state("fim_t", SFimT);
    check_eq("fimt_flag", bus.db_timeout, 1);
    check_eq("fimt_perdeu", bus.perdeu, 1);
    check_eq("fimt_pronto", bus.pronto, 1);
    check_eq("fimt_vidas", bus.vidas, 0);

    // Asynchronous reset in the middle of a replay
    bus.timeout_en = 1'b0;
    start_game(1'b0);
    expect_span("show_first_rs", SShowFirst, 8);
    round_ok(0);
    expect_span("show_ok_rs", SShowOk, 4);
    tick();
    tick();
    expect_span("show_seq_rs", SShowSeq, 4);
    expect_span("show_gap_rs", SShowGap, 2);
    expect_state("show_seq_rs2", SShowSeq);
    check_eq("pre_reset_end", bus.endereco, 1);
    #2;
    reset = 1'b1;
    #1;
    expect_state("async_reset", SIdle);
    check_eq("reset_end", bus.endereco, 0);
    check_eq("reset_rod", bus.rodada, 0);
    check_eq("reset_vidas", bus.vidas, 2);
    tick();
    reset = 1'b0;
    tick();
    expect_state("after_reset", SIdle);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
